// File: rtl/pipe_scroller_pkg.sv
// Shared definitions for the pipe scroller: pipe-word layout, screen constants,
// game state encoding and small combinational helpers.
package pipe_scroller_pkg;

    localparam int H_LSB    = 0;
    localparam int H_W      = 10;
    localparam int X_LSB    = 10;
    localparam int X_W      = 10;
    localparam int GAP_LSB  = 20;
    localparam int GAP_W    = 8;
    localparam int PIPE_W   = 50;
    localparam int SCREEN_W = 640;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_e;

    function automatic logic [31:0] pack_pipe(input logic [H_W-1:0] h,
                                              input logic [X_W-1:0] x,
                                              input logic [GAP_W-1:0] gap);
        logic [31:0] w;
        w = '0;
        w[H_LSB +: H_W]     = h;
        w[X_LSB +: X_W]     = x;
        w[GAP_LSB +: GAP_W] = gap;
        return w;
    endfunction

    // Four-digit BCD +1 with per-digit carry; holds at 9999 instead of wrapping.
    function automatic logic [15:0] bcd_inc_sat(input logic [15:0] s);
        logic [15:0] r;
        logic        carry;
        r     = s;
        carry = 1'b1;
        if (s != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                if (carry) begin
                    if (r[d*4 +: 4] == 4'd9) begin
                        r[d*4 +: 4] = 4'd0;
                    end else begin
                        r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_scroller_if.sv
// Bundle between the game-control side and the pipe scroller.
interface pipe_scroller_if;
    import pipe_scroller_pkg::*;

    // No valid/ready here: f_tick, start and pass are single-cycle pulses sampled on the
    // rising clock edge; fail is a level; pipe words and score are registered and stable.
    logic        f_tick;
    logic        start;
    logic        fail;
    logic [31:0] pipe_1;
    logic [31:0] pipe_2;
    logic [31:0] pipe_3;
    logic [15:0] score;
    logic        pass;
    state_e      state_dbg;

    modport master (
        output f_tick, start, fail,
        input  pipe_1, pipe_2, pipe_3, score, pass, state_dbg
    );

    modport slave (
        input  f_tick, start, fail,
        output pipe_1, pipe_2, pipe_3, score, pass, state_dbg
    );

endinterface

// File: rtl/pipe_scroller_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with 16'hACE1 on reset.
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/pipe_scroller.sv
// Scrolls three pipe groups left once per frame, recycles off-screen pipes behind the
// rightmost one with a random height, and keeps the BCD score.
module pipe_scroller
    import pipe_scroller_pkg::*;
#(
    parameter int SPEED   = 2,
    parameter int SPACING = 220,
    parameter int FIRST_X = 400,
    parameter int GAP     = 120,
    parameter int MIN_H   = 60,
    parameter int BIRD_X  = 40,
    parameter int INIT_H1 = 150,
    parameter int INIT_H2 = 200,
    parameter int INIT_H3 = 120
) (
    input  logic        clk,
    input  logic        rst,
    pipe_scroller_if.slave bus
);

    localparam logic [9:0] SPEED_V   = 10'(SPEED);
    localparam logic [9:0] SPACING_V = 10'(SPACING);
    localparam logic [9:0] MIN_H_V   = 10'(MIN_H);
    localparam logic [9:0] BIRD_V    = 10'(BIRD_X);
    localparam logic [7:0] GAP_V     = 8'(GAP);
    localparam logic [9:0] X1_V      = 10'(FIRST_X);
    localparam logic [9:0] X2_V      = 10'(FIRST_X + SPACING);
    localparam logic [9:0] X3_V      = 10'(FIRST_X + 2 * SPACING);
    localparam logic [9:0] H1_V      = 10'(INIT_H1);
    localparam logic [9:0] H2_V      = 10'(INIT_H2);
    localparam logic [9:0] H3_V      = 10'(INIT_H3);

    state_e      state_q, state_d;
    logic [9:0]  addr_q   [3];
    logic [9:0]  addr_d   [3];
    logic [9:0]  height_q [3];
    logic [9:0]  height_d [3];
    logic [15:0] score_q, score_d;
    logic        pass_q, pass_d;
    logic        move;
    logic        scored;
    logic [15:0] lfsr;
    logic        unused_lfsr_hi;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:8];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        height_d = height_q;
        score_d  = score_q;
        pass_d   = 1'b0;
        move     = 1'b0;
        scored   = 1'b0;

        case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN: begin
                // A collision on the same cycle as a frame tick freezes the frame.
                if (bus.fail) state_d = DEAD;
                else if (bus.f_tick) move = 1'b1;
            end
            DEAD: begin
                if (bus.start) begin
                    state_d     = IDLE;
                    addr_d[0]   = X1_V;
                    addr_d[1]   = X2_V;
                    addr_d[2]   = X3_V;
                    height_d[0] = H1_V;
                    height_d[1] = H2_V;
                    height_d[2] = H3_V;
                    score_d     = 16'h0000;
                end
            end
            default: state_d = IDLE;
        endcase

        if (move) begin
            for (int i = 0; i < 3; i++) begin
                // The ring predecessor is never recycling on the same tick since SPACING > SPEED.
                if (addr_q[i] < SPEED_V) begin
                    addr_d[i]   = addr_q[(i + 2) % 3] - SPEED_V + SPACING_V;
                    height_d[i] = MIN_H_V + {2'b00, lfsr[7:0]};
                end else begin
                    addr_d[i] = addr_q[i] - SPEED_V;
                    if ((addr_q[i] >= BIRD_V) && ((addr_q[i] - SPEED_V) < BIRD_V)) scored = 1'b1;
                end
            end
            if (scored) begin
                pass_d  = 1'b1;
                score_d = bcd_inc_sat(score_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q[0]   <= X1_V;
            addr_q[1]   <= X2_V;
            addr_q[2]   <= X3_V;
            height_q[0] <= H1_V;
            height_q[1] <= H2_V;
            height_q[2] <= H3_V;
            score_q     <= 16'h0000;
            pass_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            height_q <= height_d;
            score_q  <= score_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.pipe_1    = pack_pipe(height_q[0], addr_q[0], GAP_V);
    assign bus.pipe_2    = pack_pipe(height_q[1], addr_q[1], GAP_V);
    assign bus.pipe_3    = pack_pipe(height_q[2], addr_q[2], GAP_V);
    assign bus.score     = score_q;
    assign bus.pass      = pass_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: default instance for layout/scroll/recycle/fail,
// plus a fast-scrolling instance to reach BCD carry and score saturation quickly.
module tb_pipe_scroller;
    import pipe_scroller_pkg::*;

    logic        clk;
    logic        rst;
    int          checks;
    int          errors;
    int          npass;
    int          fcount;
    logic [15:0] m_lfsr;
    logic [15:0] snap;
    int          exp_h;

    pipe_scroller_if pif ();
    pipe_scroller_if fif ();

    pipe_scroller u_dut (
        .clk (clk),
        .rst (rst),
        .bus (pif.slave)
    );

    pipe_scroller #(.SPEED(40), .SPACING(50)) u_fast (
        .clk (clk),
        .rst (rst),
        .bus (fif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR written in the shift-right/feedback-in-MSB form.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= (m_lfsr >> 1) |
                           (16'((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'h1) << 15);
    end

    function automatic logic [31:0] pw(input int h, input int x);
        return {4'h0, 8'd120, 10'(x), 10'(h)};
    endfunction

    function automatic logic [31:0] x_of(input logic [31:0] w);
        return {22'd0, w[19:10]};
    endfunction

    function automatic logic [31:0] h_of(input logic [31:0] w);
        return {22'd0, w[9:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        pif.f_tick = 1'b1;
        snap       = m_lfsr;
        @(negedge clk);
        pif.f_tick = 1'b0;
        if (pif.pass) npass++;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        pif.start = 1'b1;
        @(negedge clk);
        pif.start = 1'b0;
    endtask

    task automatic check_reset_layout(input string tag);
        check({tag, "_p1"}, pif.pipe_1, 32'h07864096);
        check({tag, "_p2"}, pif.pipe_2, pw(200, 620));
        check({tag, "_p3"}, pif.pipe_3, pw(120, 840));
        check({tag, "_score"}, {16'd0, pif.score}, 32'h0);
        check({tag, "_state"}, {30'd0, pif.state_dbg}, {30'd0, IDLE});
    endtask

    initial begin
        checks = 0; errors = 0; npass = 0; fcount = 0;
        rst = 1'b1;
        pif.f_tick = 1'b0; pif.start = 1'b0; pif.fail = 1'b0;
        fif.f_tick = 1'b0; fif.start = 1'b0; fif.fail = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_reset_layout("rst");
        check("rst_pass", {31'd0, pif.pass}, 32'h0);

        tick();
        check("idle_tick_p1", pif.pipe_1, 32'h07864096);

        pulse_start();
        check("run_state", {30'd0, pif.state_dbg}, {30'd0, RUN});
        repeat (10) tick();
        check("t10_x1", x_of(pif.pipe_1), 32'd380);
        check("t10_x2", x_of(pif.pipe_2), 32'd600);
        check("t10_x3", x_of(pif.pipe_3), 32'd820);
        check("t10_h1", h_of(pif.pipe_1), 32'd150);
        check("t10_h2", h_of(pif.pipe_2), 32'd200);
        check("t10_h3", h_of(pif.pipe_3), 32'd120);

        pulse_start();
        check("start_in_run", {30'd0, pif.state_dbg}, {30'd0, RUN});

        repeat (170) tick();
        check("t180_x1", x_of(pif.pipe_1), 32'd40);
        check("t180_npass", 32'(npass), 32'd0);
        tick();
        check("t181_x1", x_of(pif.pipe_1), 32'd38);
        check("t181_pass", {31'd0, pif.pass}, 32'h1);
        check("t181_score", {16'd0, pif.score}, 32'h0001);
        @(negedge clk);
        check("t181_pass_drop", {31'd0, pif.pass}, 32'h0);

        repeat (19) tick();
        check("t200_x1", x_of(pif.pipe_1), 32'd0);
        check("t200_x3", x_of(pif.pipe_3), 32'd440);
        tick();
        exp_h = 60 + int'(snap[7:0]);
        check("t201_x1", x_of(pif.pipe_1), 32'd658);
        check("t201_h1", h_of(pif.pipe_1), 32'(exp_h));
        check("t201_h1_range", {31'd0, (h_of(pif.pipe_1) >= 60) && (h_of(pif.pipe_1) <= 315)}, 32'h1);
        check("t201_gap", {24'd0, pif.pipe_1[27:20]}, 32'd120);
        check("t201_top", {28'd0, pif.pipe_1[31:28]}, 32'h0);
        check("t201_x2", x_of(pif.pipe_2), 32'd218);

        repeat (969) tick();
        check("t1170_score", {16'd0, pif.score}, 32'h0009);
        tick();
        check("t1171_score", {16'd0, pif.score}, 32'h0010);
        check("t1171_npass", 32'(npass), 32'd10);
        check("t1171_x1", x_of(pif.pipe_1), 32'd38);

        @(negedge clk);
        pif.f_tick = 1'b1; pif.fail = 1'b1;
        @(negedge clk);
        pif.f_tick = 1'b0; pif.fail = 1'b0;
        check("fail_state", {30'd0, pif.state_dbg}, {30'd0, DEAD});
        check("fail_x1", x_of(pif.pipe_1), 32'd38);
        repeat (5) tick();
        check("dead_x1", x_of(pif.pipe_1), 32'd38);
        check("dead_x2", x_of(pif.pipe_2), 32'd258);
        check("dead_x3", x_of(pif.pipe_3), 32'd478);
        check("dead_score", {16'd0, pif.score}, 32'h0010);

        pulse_start();
        check_reset_layout("restart");

        pulse_start();
        repeat (3) tick();
        check("rerun_x1", x_of(pif.pipe_1), 32'd394);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_layout("midrst");

        // Fast instance: one tick per cycle, pass pulses counted to hit carry and saturation.
        @(negedge clk);
        fif.start = 1'b1;
        @(negedge clk);
        fif.start  = 1'b0;
        fif.f_tick = 1'b1;
        for (int c = 0; c < 20000 && fcount < 10005; c++) begin
            @(negedge clk);
            if (fif.pass) begin
                fcount++;
                if (fcount == 10)   check("fast_10",   {16'd0, fif.score}, 32'h0010);
                if (fcount == 100)  check("fast_100",  {16'd0, fif.score}, 32'h0100);
                if (fcount == 9998) check("fast_9998", {16'd0, fif.score}, 32'h9998);
                if (fcount == 9999) check("fast_9999", {16'd0, fif.score}, 32'h9999);
            end
        end
        fif.f_tick = 1'b0;
        check("fast_budget", {31'd0, fcount >= 10005}, 32'h1);
        check("fast_sat", {16'd0, fif.score}, 32'h9999);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
